// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Contents: opcode constants, state encoding, ALU operand-B select,
// ALU op class and PC source encodings.
// Optional feature macro used by importers: MCTRL_BNE_EN (BNE decode).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_J_EX     = 4'd11,
    S_BNE_EX   = 4'd12
  } state_t;

  // ALU operand B select
  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_next_state.sv
// Combinational next-state decode for the multi-cycle MIPS control FSM.
// Ports:
//   i_state     current state
//   i_opcode    IR opcode field
//   i_mem_ready memory handshake (only consulted in FETCH/MEMRD/MEMWR)
//   o_next      next state
//   o_bad_op    DECODE saw an opcode this build does not implement
// Optional feature macro: MCTRL_BNE_EN adds the BNE_EX path.
module mips_ctrl_next_state
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  state_t           i_state,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_mem_ready,
  output state_t           o_next,
  output logic             o_bad_op
);

  always_comb begin
    o_next   = S_FETCH;
    o_bad_op = 1'b0;
    case (i_state)
      S_FETCH:    o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: o_next = S_MEMADR;
          OP_R:         o_next = S_RTYPE_EX;
          OP_BEQ:       o_next = S_BEQ_EX;
          OP_ADDI:      o_next = S_ADDI_EX;
          OP_J:         o_next = S_J_EX;
`ifdef MCTRL_BNE_EN
          OP_BNE:       o_next = S_BNE_EX;
`endif
          default: begin
            o_next   = S_FETCH;
            o_bad_op = 1'b1;
          end
        endcase
      end
      // Only LW/SW reach MEMADR, so anything not LW is treated as a store.
      S_MEMADR:   o_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    o_next = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    o_next = S_FETCH;
      S_MEMWR:    o_next = i_mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: o_next = S_RTYPE_WB;
      S_RTYPE_WB: o_next = S_FETCH;
      S_BEQ_EX:   o_next = S_FETCH;
      S_ADDI_EX:  o_next = S_ADDI_WB;
      S_ADDI_WB:  o_next = S_FETCH;
      S_J_EX:     o_next = S_FETCH;
`ifdef MCTRL_BNE_EN
      S_BNE_EX:   o_next = S_FETCH;
`endif
      // Unused encodings recover to FETCH.
      default:    o_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main control FSM for the multi-cycle MIPS core.
// Drives datapath register enables, mux selects, ALU op class, register
// file write and memory strobes from the current state.
// Ports:
//   CLK, RST (sync, active-high)
//   opcode, zero, mem_ready                  inputs from datapath/memory
//   pc_en, ir_en, mdr_en, ab_en, aluout_en   register write enables
//   mem_read, mem_write, iord                memory strobes / address select
//   reg_write, reg_dst, mem_to_reg           register file controls
//   alu_src_a, alu_src_b, alu_op, pc_src     datapath selects
//   state (debug), illegal (sticky bad-opcode flag)
// Optional feature macro: MCTRL_BNE_EN enables BNE (opcode 000101).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int OPC_W   = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_en,
  output logic               mdr_en,
  output logic               ab_en,
  output logic               aluout_en,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  state_t r_state;
  state_t w_next;
  logic   w_bad_op;
  logic   r_illegal;

  mips_ctrl_next_state #(.OPC_W(OPC_W)) u_next (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_next      (w_next),
    .o_bad_op    (w_bad_op)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_bad_op) r_illegal <= 1'b1;
    end
  end

  assign state   = STATE_W'(r_state);
  assign illegal = r_illegal;

  // Output decode. Everything is held at zero during RST so an instruction
  // aborted by reset cannot commit a write on the reset edge.
  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mdr_en     = 1'b0;
    ab_en      = 1'b0;
    aluout_en  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    if (!RST) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ASB_FOUR;
          ir_en     = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          ab_en     = 1'b1;
          aluout_en = 1'b1;
          alu_src_b = ASB_IMM_SH2;
        end
        S_MEMADR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          aluout_en = 1'b1;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mdr_en   = mem_ready;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
          aluout_en = 1'b1;
        end
        S_RTYPE_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero;
        end
        S_ADDI_WB: reg_write = 1'b1;
        S_J_EX: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
`ifdef MCTRL_BNE_EN
        S_BNE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = ~zero;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // Control word layout:
  // {pc_en,ir_en,mdr_en,ab_en,aluout_en}_{mem_read,mem_write,iord}_
  // {reg_write,reg_dst,mem_to_reg,alu_src_a}_{alu_src_b}_{alu_op}_{pc_src}
  localparam logic [17:0] C_ZERO   = 18'b00000_000_0000_00_00_00;
  localparam logic [17:0] C_F_R    = 18'b11000_100_0000_01_00_00;
  localparam logic [17:0] C_F_NR   = 18'b00000_100_0000_01_00_00;
  localparam logic [17:0] C_DEC    = 18'b00011_000_0000_11_00_00;
  localparam logic [17:0] C_MADR   = 18'b00001_000_0001_10_00_00;
  localparam logic [17:0] C_MRD_NR = 18'b00000_101_0000_00_00_00;
  localparam logic [17:0] C_MRD_R  = 18'b00100_101_0000_00_00_00;
  localparam logic [17:0] C_MWB    = 18'b00000_000_1010_00_00_00;
  localparam logic [17:0] C_MWR    = 18'b00000_011_0000_00_00_00;
  localparam logic [17:0] C_REX    = 18'b00001_000_0001_00_10_00;
  localparam logic [17:0] C_RWB    = 18'b00000_000_1100_00_00_00;
  localparam logic [17:0] C_AEX    = 18'b00001_000_0001_10_00_00;
  localparam logic [17:0] C_AWB    = 18'b00000_000_1000_00_00_00;
  localparam logic [17:0] C_BR_T   = 18'b10000_000_0001_00_01_01;
  localparam logic [17:0] C_BR_N   = 18'b00000_000_0001_00_01_01;
  localparam logic [17:0] C_J      = 18'b10000_000_0000_00_00_10;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [5:0]  opc;
    state_t      st;
    logic [17:0] c;
    logic        ill;
  } step_t;

  logic       CLK, RST, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [17:0] ctl;

  int n_assert = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl #(.STATE_W(4), .OPC_W(6)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .ab_en(ab_en),
    .aluout_en(aluout_en), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal(illegal)
  );

  assign ctl = {pc_en, ir_en, mdr_en, ab_en, aluout_en, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic reset_dut();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      n_assert++;
      if (state !== 4'(S_FETCH)) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d want %0d", i, state, S_FETCH); end
      n_assert++;
      if (ctl !== C_ZERO) begin n_fail++; $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, C_ZERO); end
      n_assert++;
      if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal[%0d]: got %b want 0", i, illegal); end
    end
    @(negedge CLK);
    RST = 1'b0; #1;
    n_assert++;
    if (ctl !== C_F_R) begin n_fail++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_F_R); end
    n_assert++;
    if (state !== 4'(S_FETCH)) begin n_fail++; $display("FAIL reset_release_state: got %0d want %0d", state, S_FETCH); end
  endtask

  task automatic test_wait_fetch();
    step_t seq [5] = '{
      '{L, L, L, OP_R, S_FETCH,  C_F_NR, L},
      '{L, L, L, OP_R, S_FETCH,  C_F_NR, L},
      '{L, L, L, OP_R, S_FETCH,  C_F_NR, L},
      '{L, H, L, OP_R, S_FETCH,  C_F_R,  L},
      '{L, H, L, OP_R, S_DECODE, C_DEC,  L}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL wait_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL wait_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      @(negedge CLK);
    end
  endtask

  task automatic test_lw();
    // MEMRD waits one cycle; mem_ready=0 in MEMWB must be ignored.
    step_t seq [7] = '{
      '{L, H, L, OP_LW, S_FETCH,  C_F_R,    L},
      '{L, H, L, OP_LW, S_DECODE, C_DEC,    L},
      '{L, H, L, OP_LW, S_MEMADR, C_MADR,   L},
      '{L, L, L, OP_LW, S_MEMRD,  C_MRD_NR, L},
      '{L, H, L, OP_LW, S_MEMRD,  C_MRD_R,  L},
      '{L, L, L, OP_LW, S_MEMWB,  C_MWB,    L},
      '{L, H, L, OP_LW, S_FETCH,  C_F_R,    L}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL lw_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      @(negedge CLK);
    end
  endtask

  task automatic test_beq();
    step_t seq [7] = '{
      '{L, H, H, OP_BEQ, S_FETCH,  C_F_R,  L},
      '{L, H, H, OP_BEQ, S_DECODE, C_DEC,  L},
      '{L, H, H, OP_BEQ, S_BEQ_EX, C_BR_T, L},
      '{L, H, L, OP_BEQ, S_FETCH,  C_F_R,  L},
      '{L, H, L, OP_BEQ, S_DECODE, C_DEC,  L},
      '{L, H, L, OP_BEQ, S_BEQ_EX, C_BR_N, L},
      '{L, H, L, OP_BEQ, S_FETCH,  C_F_R,  L}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL beq_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    // R, ADDI, J in sequence; mem_ready low in RTYPE_EX must not stall.
    step_t seq [12] = '{
      '{L, H, L, OP_R,    S_FETCH,    C_F_R, L},
      '{L, H, L, OP_R,    S_DECODE,   C_DEC, L},
      '{L, L, L, OP_R,    S_RTYPE_EX, C_REX, L},
      '{L, H, L, OP_R,    S_RTYPE_WB, C_RWB, L},
      '{L, H, L, OP_ADDI, S_FETCH,    C_F_R, L},
      '{L, H, L, OP_ADDI, S_DECODE,   C_DEC, L},
      '{L, H, L, OP_ADDI, S_ADDI_EX,  C_AEX, L},
      '{L, H, L, OP_ADDI, S_ADDI_WB,  C_AWB, L},
      '{L, H, L, OP_J,    S_FETCH,    C_F_R, L},
      '{L, H, L, OP_J,    S_DECODE,   C_DEC, L},
      '{L, H, L, OP_J,    S_J_EX,     C_J,   L},
      '{L, H, L, OP_J,    S_FETCH,    C_F_R, L}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL b2b_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      @(negedge CLK);
    end
  endtask

  task automatic test_illegal();
    step_t seq [7] = '{
      '{L, H, L, OP_BAD, S_FETCH,    C_F_R, L},
      '{L, H, L, OP_BAD, S_DECODE,   C_DEC, L},
      '{L, H, L, OP_R,   S_FETCH,    C_F_R, H},
      '{L, H, L, OP_R,   S_DECODE,   C_DEC, H},
      '{L, H, L, OP_R,   S_RTYPE_EX, C_REX, H},
      '{L, H, L, OP_R,   S_RTYPE_WB, C_RWB, H},
      '{L, H, L, OP_R,   S_FETCH,    C_F_R, H}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL ill_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL ill_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      n_assert++;
      if (illegal !== seq[i].ill) begin n_fail++; $display("FAIL ill_flag[%0d]: got %b want %b", i, illegal, seq[i].ill); end
      @(negedge CLK);
    end
  endtask

  task automatic test_rst_memwr();
    // Reset while a store is stalled: strobe drops immediately.
    step_t seq [7] = '{
      '{L, H, L, OP_SW, S_FETCH,  C_F_R,  L},
      '{L, H, L, OP_SW, S_DECODE, C_DEC,  L},
      '{L, H, L, OP_SW, S_MEMADR, C_MADR, L},
      '{L, L, L, OP_SW, S_MEMWR,  C_MWR,  L},
      '{L, L, L, OP_SW, S_MEMWR,  C_MWR,  L},
      '{H, L, L, OP_SW, S_MEMWR,  C_ZERO, L},
      '{L, H, L, OP_SW, S_FETCH,  C_F_R,  L}};
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL rstwr_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL rstwr_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      @(negedge CLK);
    end
  endtask

  task automatic test_bne();
`ifdef MCTRL_BNE_EN
    step_t seq [7] = '{
      '{L, H, L, OP_BNE, S_FETCH,  C_F_R,  L},
      '{L, H, L, OP_BNE, S_DECODE, C_DEC,  L},
      '{L, H, L, OP_BNE, S_BNE_EX, C_BR_T, L},
      '{L, H, H, OP_BNE, S_FETCH,  C_F_R,  L},
      '{L, H, H, OP_BNE, S_DECODE, C_DEC,  L},
      '{L, H, H, OP_BNE, S_BNE_EX, C_BR_N, L},
      '{L, H, H, OP_BNE, S_FETCH,  C_F_R,  L}};
`else
    step_t seq [3] = '{
      '{L, H, L, OP_BNE, S_FETCH,  C_F_R, L},
      '{L, H, L, OP_BNE, S_DECODE, C_DEC, L},
      '{L, H, L, OP_BNE, S_FETCH,  C_F_R, H}};
`endif
    reset_dut();
    foreach (seq[i]) begin
      RST = seq[i].rst; mem_ready = seq[i].rdy; zero = seq[i].z; opcode = seq[i].opc; #1;
      n_assert++;
      if (state !== 4'(seq[i].st)) begin n_fail++; $display("FAIL bne_state[%0d]: got %0d want %0d", i, state, seq[i].st); end
      n_assert++;
      if (ctl !== seq[i].c) begin n_fail++; $display("FAIL bne_ctl[%0d]: got %b want %b", i, ctl, seq[i].c); end
      n_assert++;
      if (illegal !== seq[i].ill) begin n_fail++; $display("FAIL bne_flag[%0d]: got %b want %b", i, illegal, seq[i].ill); end
      @(negedge CLK);
    end
  endtask

  initial begin
    RST       = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = OP_R;
    test_reset();
    test_wait_fetch();
    test_lw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_rst_memwr();
    test_bne();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS core.
- Sequences the 32-bit enable-gated datapath registers (PC, IR, MDR, A/B, ALUOut) by driving their per-register write enables.
- Also drives the mux selects, ALU op class, register-file write and memory strobes.
- Sits between the IR opcode field and the datapath. Waits on a memory ready handshake.

Parameters:
- STATE_W, 4, state register width (≥ number of states, encoded).
- OPC_W, 6, opcode field width.

Ports:
- CLK  in  1  rising-edge clock; all state changes on posedge CLK.
- RST  in  1  synchronous, active-high reset.
- opcode  in  OPC_W  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag (branch compare result).
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_en  out  1  PC register write enable.
- ir_en  out  1  IR write enable.
- mdr_en  out  1  MDR write enable.
- ab_en  out  1  A/B register write enable.
- aluout_en  out  1  ALUOut write enable.
- mem_read / mem_write  out  1 each  memory strobes.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  STATE_W  current state (debug).
- illegal  out  1  sticky: unknown opcode decoded.

Behaviour:
- Reset: RST=1 at posedge → state=FETCH, illegal=0.
  - While RST=1, all enables/strobes/reg_write are forced 0 combinationally. Selects are don't-care but driven 0.
- Outputs are decoded from state only, except where noted (zero, mem_ready gating).
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- FETCH
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_en=pc_en=mem_ready. Stay in FETCH until mem_ready=1, then → DECODE.
- DECODE
  - ab_en=1, aluout_en=1, alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state: LW/SW → MEMADR; R → RTYPE_EX; BEQ → BEQ_EX; ADDI → ADDI_EX; J → J_EX.
  - Any other opcode → FETCH and set illegal=1. No register or memory written.
- MEMADR: alu_src_a=1, alu_src_b=10, aluout_en=1. → MEMRD if LW, MEMWR if SW.
- MEMRD: mem_read=1, iord=1, mdr_en=mem_ready. Hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. → FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then → FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10, aluout_en=1. → RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. → FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. → FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00, aluout_en=1. → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. → FETCH.
- J_EX: pc_src=10, pc_en=1. → FETCH.
- Latency (mem_ready always 1): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.
- Illegal state encodings → FETCH next cycle; outputs inactive.
- RST asserted mid-instruction: aborts on that edge. No writeback occurs in the RST cycle because enables are gated.
- illegal clears only on RST.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro MCTRL_BNE_EN.
- Defined: opcode 000101 (BNE) is decoded in DECODE → BNE_EX.
  - BNE_EX is identical to BEQ_EX except pc_en = ~zero.
- Undefined: 000101 is treated as illegal (→ FETCH, illegal=1).

Decomposition:
- Shared package mips_ctrl_pkg:
  - Opcode constants.
  - State encoding constants.
  - alu_src_b, alu_op and pc_src encodings.
- Optional sub-module mips_ctrl_next_state: combinational next-state decode, kept separate from the output decode.
- The state register stays in the top module.

Test Plan:
- Reset: hold RST=1 for 2 cycles, mem_ready=1 → state=FETCH, all enables 0 during RST, illegal=0. After release: ir_en=pc_en=1 in the first cycle.
- Wait-state fetch: mem_ready=0 for 3 cycles then 1 → state stays FETCH, ir_en/pc_en=0 until the ready cycle, DECODE the cycle after.
- LW (100011), mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. mdr_en=1 in MEMRD; reg_write=1 with mem_to_reg=1 in MEMWB.
- BEQ with zero=1, then zero=0 → pc_en=1 with pc_src=01 in BEQ_EX the first time; pc_en=0 the second time. Both return to FETCH.
- Opcode 111111 → DECODE→FETCH, illegal=1 and stays set through the next R-type. No reg_write or mem_write pulse.
- RST asserted during MEMWR with mem_ready=0 → mem_write drops the same cycle, state=FETCH next. With MCTRL_BNE_EN defined: opcode 000101 with zero=0 → pc_en=1.
